bbpu_reg_bank: RTL
==================

BBPU_REG_BANK -- requirements
Module: bbpu_reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, number of bidirectional pad bits (1..32).
REQ-002 Parameter TURN_CYCLES, default 2, bus-release cycles inserted at every direction change (0..15).
REQ-003 Parameter PULLUP, default 1, 1 = weak pullup on every pad bit, 0 = no pull.
REQ-004 Port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port LSR  input  1  reset, synchronous, active-high.
REQ-006 Port I  input  WIDTH  data to drive onto the pads.
REQ-007 Port T  input  1  direction request; 0 = drive pads, 1 = release pads.
REQ-008 Port TSALL  input  1  global tristate, active-high; overrides T.
REQ-009 Port O  output  WIDTH  registered pad input data.
REQ-010 Port O_VALID  output  1  O holds a sample taken while the bus was released and settled.
REQ-011 Port DRIVING  output  1  pads are currently driven by this block.
REQ-012 Port B  inout  WIDTH  pad bits.

Function
REQ-013 FSM states: RX, TURN_TX, TX, TURN_RX; counter TC is 4 bits wide and counts release cycles.
REQ-014 RX: pads released; if T=0 and TSALL=0 -> TURN_TX with TC=0 (or -> TX directly when TURN_CYCLES=0).
REQ-015 TURN_TX: pads released; TC increments each cycle; -> TX when TC reaches TURN_CYCLES-1.
REQ-016 TURN_TX with T=1: abort to RX next cycle; pads are never driven.
REQ-017 TX: pads driven from output register Q; if T=1 -> TURN_RX with TC=0 (or -> RX when TURN_CYCLES=0).
REQ-018 TURN_RX: pads released; runs the full TURN_CYCLES count and ignores T; then -> RX, and RX re-evaluates T.
REQ-019 Output register Q loads I on every edge in every state, so the first TX cycle drives the I value sampled one edge earlier.
REQ-020 DRIVING is registered; it is 1 exactly in state TX with TSALL=0.
REQ-021 Pad driver: B[n] = Q[n] when DRIVING=1 and TSALL=0, else high-impedance; TSALL releases the pads combinationally in the same cycle.
REQ-022 TSALL=1 sampled in TX or TURN_TX: FSM goes to TURN_RX (from TX) or RX (from TURN_TX) and stays out of TX while TSALL=1.
REQ-023 PULLUP=1: each released pad resolves to 1 when there is no external driver; the driver's strength beats the pull.
REQ-024 O loads B on every edge; O_VALID is 1 for a sample captured in RX, else 0 (O is still updated).
REQ-025 Latency: pad change to O is 1 cycle; T falling edge to first driven cycle is TURN_CYCLES+1 cycles.

Reset
REQ-026 LSR=1 at an edge: state RX, TC=0, Q=0, O=0, O_VALID=0, DRIVING=0; this holds for every state.
REQ-027 Pads are released from the first edge with LSR=1, including during TX mid-transfer.
REQ-028 First edge after LSR deasserts: normal operation; O_VALID rises one cycle after reset release when in RX.

Verification
REQ-029 WIDTH=8, TURN_CYCLES=2, T=1, B undriven, PULLUP=1 -> O=8'hFF with O_VALID=1 after 1 cycle; DRIVING=0.
REQ-030 T 1->0 with I=8'hA5 held -> two released cycles (TURN_TX), then B=8'hA5 and DRIVING=1 on the 3rd edge.
REQ-031 In TX, T 0->1 -> B released next edge, O_VALID=0 for 2 cycles, then 1 with O=external value (8'h3C).
REQ-032 T low for 1 cycle only in RX -> TURN_TX aborted, B never driven, DRIVING stays 0.
REQ-033 TSALL pulsed in TX -> B high-impedance in the same cycle; FSM enters TURN_RX; driving resumes only after TSALL=0 and a full turnaround.
REQ-034 LSR asserted mid-TX -> next edge: DRIVING=0, O=0, O_VALID=0, state RX; TURN_CYCLES=0 build: T toggles drive/release in 1 cycle.

Source files
------------

// File: rtl/bbpu_reg_bank.sv
// Bidirectional pad bank with a turnaround-guarded direction FSM, a registered
// output driver and a registered pad sampler flagged valid only while released.
module bbpu_reg_bank #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter bit PULLUP      = 1'b1
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic [WIDTH-1:0] I,
  input  logic             T,
  input  logic             TSALL,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  output logic             DRIVING,
  inout  wire  [WIDTH-1:0] B
);

  typedef enum logic [1:0] {RX, TURN_TX, TX, TURN_RX} state_t;

  localparam bit         NO_TURN = (TURN_CYCLES == 0);
  localparam logic [3:0] TC_LAST = 4'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);

  state_t           state, state_next;
  logic [3:0]       tc, tc_next;
  logic [WIDTH-1:0] q;
  logic             release_req;

  assign release_req = T | TSALL;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    tc_next    = tc;
    unique case (state)
      RX: begin
        if (!release_req) begin
          tc_next = '0;
          if (NO_TURN) state_next = TX;
          else         state_next = TURN_TX;
        end
      end
      TURN_TX: begin
        if (release_req) begin
          state_next = RX;
          tc_next    = '0;
        end else if (tc == TC_LAST) begin
          state_next = TX;
          tc_next    = '0;
        end else begin
          tc_next = tc + 4'd1;
        end
      end
      TX: begin
        if (release_req) begin
          tc_next = '0;
          if (NO_TURN) state_next = RX;
          else         state_next = TURN_RX;
        end
      end
      TURN_RX: begin
        // The release turnaround always runs to completion; T is ignored here.
        if (tc == TC_LAST) begin
          state_next = RX;
          tc_next    = '0;
        end else begin
          tc_next = tc + 4'd1;
        end
      end
      default: begin
        state_next = RX;
        tc_next    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (LSR) begin
      state   <= RX;
      tc      <= '0;
      q       <= '0;
      O       <= '0;
      O_VALID <= 1'b0;
      DRIVING <= 1'b0;
    end else begin
      state   <= state_next;
      tc      <= tc_next;
      q       <= I;
      O       <= B;
      O_VALID <= (state == RX);
      DRIVING <= (state_next == TX);
    end
  end

  // TSALL releases the pads combinationally, without waiting for an edge.
  assign B = (DRIVING && !TSALL) ? q : {WIDTH{1'bz}};

  if (PULLUP) begin : g_pull
    for (genvar n = 0; n < WIDTH; n++) begin : g_bit
      pullup pu (B[n]);
    end
  end

endmodule
